// File: rtl/uart_tx_arbiter.sv
// Two-requester, packet-locked round-robin arbiter feeding a byte-wide UART transmitter.
// Optional build macro HEADER_EN_EN prefixes each packet with 8'hA5 and the granted requester id.
module uart_tx_arbiter #(
   parameter logic [15:0] IDLE_TIMEOUT = 16'd50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rq0_valid,
   input  logic [7:0] rq0_data,
   input  logic       rq0_last,
   output logic       rq0_ready,
   input  logic       rq1_valid,
   input  logic [7:0] rq1_data,
   input  logic       rq1_last,
   output logic       rq1_ready,
   input  logic       tx_done,
   output logic [7:0] uart_tx,
   output logic       uart_trmt,
   output logic [1:0] grant,
   output logic       abort
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ARB       = 3'd1;
`ifdef HEADER_EN_EN
   localparam logic [2:0] S_HDR       = 3'd2;
`endif
   localparam logic [2:0] S_LOAD      = 3'd3;
   localparam logic [2:0] S_SEND      = 3'd4;
   localparam logic [2:0] S_WAIT_DONE = 3'd5;

   logic [2:0]  r_state;
   logic [1:0]  r_grant;
   logic        r_last_grant;   // 1 = rq1 was granted most recently
   logic [7:0]  r_tx_byte;
   logic        r_tx_last;
   logic [15:0] r_timeout;
   logic        r_abort;
`ifdef HEADER_EN_EN
   logic        r_in_hdr;
   logic        r_hdr_idx;
`endif

   logic        w_owner_vld;
   logic [7:0]  w_owner_dat;
   logic        w_owner_last;
   logic        w_xfer;
   logic        w_win1;
   logic [15:0] w_timeout_nxt;

   assign w_owner_vld   = (r_grant[0] & rq0_valid) | (r_grant[1] & rq1_valid);
   assign w_owner_dat   = r_grant[1] ? rq1_data : rq0_data;
   assign w_owner_last  = r_grant[1] ? rq1_last : rq0_last;
   assign w_xfer        = (r_state == S_LOAD) && w_owner_vld;
   assign w_win1        = rq1_valid && (!rq0_valid || !r_last_grant);
   assign w_timeout_nxt = r_timeout + 16'd1;

   assign rq0_ready = w_xfer && r_grant[0];
   assign rq1_ready = w_xfer && r_grant[1];
   assign uart_trmt = (r_state == S_SEND);
   assign uart_tx   = r_tx_byte;
   assign grant     = r_grant;
   assign abort     = r_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_grant      <= 2'b00;
         r_last_grant <= 1'b1;
         r_tx_byte    <= 8'h00;
         r_tx_last    <= 1'b0;
         r_timeout    <= 16'd0;
         r_abort      <= 1'b0;
`ifdef HEADER_EN_EN
         r_in_hdr     <= 1'b0;
         r_hdr_idx    <= 1'b0;
`endif
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rq0_valid || rq1_valid) r_state <= S_ARB;
            end
            S_ARB: begin
               if (rq0_valid || rq1_valid) begin
                  r_grant      <= w_win1 ? 2'b10 : 2'b01;
                  r_last_grant <= w_win1;
`ifdef HEADER_EN_EN
                  r_state      <= S_HDR;
`else
                  r_state      <= S_LOAD;
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
`ifdef HEADER_EN_EN
            S_HDR: begin
               r_tx_byte <= r_hdr_idx ? {7'd0, r_grant[1]} : 8'hA5;
               r_in_hdr  <= 1'b1;
               r_state   <= S_SEND;
            end
`endif
            S_LOAD: begin
               if (w_owner_vld) begin
                  r_tx_byte <= w_owner_dat;
                  r_tx_last <= w_owner_last;
                  r_timeout <= 16'd0;
                  r_state   <= S_SEND;
               end else if (w_timeout_nxt == IDLE_TIMEOUT) begin
                  // stalled owner loses the grant and the tie-break
                  r_timeout    <= 16'd0;
                  r_abort      <= 1'b1;
                  r_last_grant <= r_grant[1];
                  r_grant      <= 2'b00;
                  r_state      <= S_IDLE;
               end else begin
                  r_timeout <= w_timeout_nxt;
               end
            end
            S_SEND: begin
               r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (tx_done) begin
`ifdef HEADER_EN_EN
                  if (r_in_hdr) begin
                     r_in_hdr  <= 1'b0;
                     r_hdr_idx <= ~r_hdr_idx;
                     r_state   <= r_hdr_idx ? S_LOAD : S_HDR;
                  end else
`endif
                  if (r_tx_last) begin
                     r_grant <= 2'b00;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected {grant, byte} pairs queued at stimulus, popped on uart_trmt.
module tb_uart_tx_arbiter;
   localparam int DONE_DLY = 10;
   localparam int TMO      = 8;
`ifdef HEADER_EN_EN
   localparam int HDR_N = 2;
`else
   localparam int HDR_N = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rq0_valid = 1'b0, rq1_valid = 1'b0;
   logic [7:0] rq0_data = 8'h00, rq1_data = 8'h00;
   logic       rq0_last = 1'b0, rq1_last = 1'b0;
   logic       rq0_ready, rq1_ready;
   logic       tx_done;
   logic       tx_done_auto = 1'b0, tx_done_man = 1'b0;
   logic [7:0] uart_tx;
   logic       uart_trmt;
   logic [1:0] grant;
   logic       abort;

   int errors = 0, checks = 0, cyc = 0;
   logic [9:0] exp_q [$];
   int trmt_cnt [2], first_gap [2], first_trmt_cyc [2], vld_cyc [2];
   int done_cyc = 0, abort_cnt = 0, abort_gap = 0;
   logic [7:0] sent_byte = 8'h00;
   bit done_en = 1'b1;
   int mon_id;
   logic [9:0] mon_e;

   assign tx_done = tx_done_auto | tx_done_man;

   uart_tx_arbiter #(.IDLE_TIMEOUT(16'(TMO))) dut (
      .clk(clk), .rst_n(rst_n),
      .rq0_valid(rq0_valid), .rq0_data(rq0_data), .rq0_last(rq0_last), .rq0_ready(rq0_ready),
      .rq1_valid(rq1_valid), .rq1_data(rq1_data), .rq1_last(rq1_last), .rq1_ready(rq1_ready),
      .tx_done(tx_done), .uart_tx(uart_tx), .uart_trmt(uart_trmt), .grant(grant), .abort(abort)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // output monitor: scoreboard pop on trmt, ownership of ready, abort context
   always @(negedge clk) begin
      if (rst_n) begin
         if (uart_trmt === 1'b1) begin
            checks++;
            mon_id = (grant == 2'b10) ? 1 : 0;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL trmt_unexpected: got grant=%b byte=%02h, required no trmt", grant, uart_tx);
            end else begin
               mon_e = exp_q.pop_front();
               if ({grant, uart_tx} !== mon_e)
                  begin errors++; $display("FAIL trmt_byte: got grant=%b byte=%02h, required grant=%b byte=%02h", grant, uart_tx, mon_e[9:8], mon_e[7:0]); end
            end
            if (trmt_cnt[mon_id] == 0) begin
               first_trmt_cyc[mon_id] = cyc;
               first_gap[mon_id] = cyc - done_cyc;
            end
            trmt_cnt[mon_id]++;
            sent_byte = uart_tx;
         end
         if (rq0_ready === 1'b1 || rq1_ready === 1'b1) begin
            checks++;
            if ({rq1_ready, rq0_ready} !== grant)
               begin errors++; $display("FAIL ready_owner: got ready=%b%b grant=%b, required ready to match grant", rq1_ready, rq0_ready, grant); end
         end
         if (abort === 1'b1) begin
            checks++;
            abort_cnt++;
            abort_gap = cyc - done_cyc;
            if (grant !== 2'b00 || uart_trmt !== 1'b0)
               begin errors++; $display("FAIL abort_ctx: got grant=%b trmt=%b, required grant=00 trmt=0", grant, uart_trmt); end
         end
      end
   end

   // transmitter model: tx_done DONE_DLY cycles after each trmt
   initial begin
      forever begin
         @(negedge clk);
         if (uart_trmt === 1'b1 && done_en) begin
            repeat (DONE_DLY - 1) @(negedge clk);
            tx_done_auto = 1'b1;
            done_cyc = cyc + 1;
            #1;
            if (grant !== 2'b00) begin
               checks++;
               if (uart_tx !== sent_byte)
                  begin errors++; $display("FAIL tx_hold: got uart_tx=%02h at tx_done, required %02h", uart_tx, sent_byte); end
            end
            @(negedge clk);
            tx_done_auto = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void push_pkt(input int id, input logic [7:0] b0, b1, b2, input int n);
      logic [1:0] g;
      logic [7:0] bb [3];
      g = (id == 1) ? 2'b10 : 2'b01;
      bb[0] = b0; bb[1] = b1; bb[2] = b2;
`ifdef HEADER_EN_EN
      exp_q.push_back({g, 8'hA5});
      exp_q.push_back({g, (id == 1) ? 8'h01 : 8'h00});
`endif
      for (int i = 0; i < n; i++) exp_q.push_back({g, bb[i]});
   endfunction

   task automatic set_rq(input int id, input logic v, input logic [7:0] d, input logic l);
      if (id == 0) begin rq0_valid = v; rq0_data = d; rq0_last = l; end
      else begin rq1_valid = v; rq1_data = d; rq1_last = l; end
   endtask

   task automatic drive(input int id, input logic [7:0] b0, b1, b2, input int n, input bit with_last);
      logic [7:0] bb [3];
      int w;
      bit got;
      bb[0] = b0; bb[1] = b1; bb[2] = b2;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         set_rq(id, 1'b1, bb[i], with_last && (i == n - 1));
         if (i == 0) vld_cyc[id] = cyc;
         w = 0; got = 1'b0;
         while (!got && w < 3000) begin
            #1;
            if (((id == 0) ? rq0_ready : rq1_ready) === 1'b1) got = 1'b1;
            else begin @(negedge clk); w++; end
         end
         if (!got) begin
            checks++; errors++;
            $display("FAIL drive_rq%0d_byte%0d: ready stayed 0 for %0d cycles, required 1", id, i, w);
         end
         @(posedge clk);
      end
      @(negedge clk);
      set_rq(id, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_trmt(input int id, input int n);
      int w;
      w = 0;
      while (trmt_cnt[id] < n && w < 3000) begin @(negedge clk); #1; w++; end
      if (trmt_cnt[id] < n) begin
         checks++; errors++;
         $display("FAIL wait_trmt_rq%0d: got %0d trmts, required %0d", id, trmt_cnt[id], n);
      end
   endtask

   task automatic wait_idle(input string name);
      int w;
      w = 0;
      while (!(exp_q.size() == 0 && grant === 2'b00) && w < 3000) begin @(negedge clk); #1; w++; end
      checks++;
      if (exp_q.size() != 0 || grant !== 2'b00)
         begin errors++; $display("FAIL %s_idle: got %0d pending bytes grant=%b, required 0 pending grant=00", name, exp_q.size(), grant); end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_rq(0, 1'b0, 8'h00, 1'b0);
      set_rq(1, 1'b0, 8'h00, 1'b0);
      tx_done_man = 1'b0;
      done_en = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin trmt_cnt[i] = 0; first_gap[i] = 0; first_trmt_cyc[i] = 0; vld_cyc[i] = 0; end
      done_cyc = 0; abort_cnt = 0; abort_gap = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, required 00", grant); end
      checks++; if (uart_tx !== 8'h00) begin errors++; $display("FAIL reset_uart_tx: got %02h, required 00", uart_tx); end
      checks++; if ({uart_trmt, rq0_ready, rq1_ready, abort} !== 4'b0000)
         begin errors++; $display("FAIL reset_pulses: got trmt/rdy0/rdy1/abort=%b, required 0000", {uart_trmt, rq0_ready, rq1_ready, abort}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if ({uart_trmt, rq0_ready, rq1_ready, abort, grant} !== 6'b0)
         begin errors++; $display("FAIL post_reset_quiet: got trmt/rdy0/rdy1/abort/grant=%b, required 000000", {uart_trmt, rq0_ready, rq1_ready, abort, grant}); end
   endtask

   task automatic test_single();
      do_reset();
      push_pkt(0, 8'h11, 8'h22, 8'h33, 3);
      drive(0, 8'h11, 8'h22, 8'h33, 3, 1'b1);
      wait_idle("single");
      checks++; if (first_trmt_cyc[0] != vld_cyc[0] + 3)
         begin errors++; $display("FAIL single_latency: got %0d cycles, required 3", first_trmt_cyc[0] - vld_cyc[0]); end
      checks++; if (trmt_cnt[0] != HDR_N + 3)
         begin errors++; $display("FAIL single_count: got %0d trmts, required %0d", trmt_cnt[0], HDR_N + 3); end
      checks++; if (trmt_cnt[1] != 0)
         begin errors++; $display("FAIL single_rq1_idle: got %0d rq1 trmts, required 0", trmt_cnt[1]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push_pkt(0, 8'hA1, 8'hA2, 8'h00, 2);
      push_pkt(1, 8'hB1, 8'hB2, 8'h00, 2);
      push_pkt(0, 8'hC1, 8'h00, 8'h00, 1);
      fork
         begin
            drive(0, 8'hA1, 8'hA2, 8'h00, 2, 1'b1);
            drive(0, 8'hC1, 8'h00, 8'h00, 1, 1'b1);
         end
         drive(1, 8'hB1, 8'hB2, 8'h00, 2, 1'b1);
      join
      wait_idle("tie");
      checks++; if (trmt_cnt[0] != 2 * HDR_N + 3 || trmt_cnt[1] != HDR_N + 2)
         begin errors++; $display("FAIL tie_counts: got rq0=%0d rq1=%0d, required rq0=%0d rq1=%0d", trmt_cnt[0], trmt_cnt[1], 2 * HDR_N + 3, HDR_N + 2); end
   endtask

   task automatic test_wait_owner();
      do_reset();
      push_pkt(0, 8'h41, 8'h42, 8'h43, 3);
      push_pkt(1, 8'h61, 8'h62, 8'h00, 2);
      fork
         drive(0, 8'h41, 8'h42, 8'h43, 3, 1'b1);
         begin
            wait_trmt(0, 1);
            drive(1, 8'h61, 8'h62, 8'h00, 2, 1'b1);
         end
      join
      wait_idle("wait");
      checks++; if (first_gap[1] < 3)
         begin errors++; $display("FAIL wait_gap: got rq1 first trmt %0d cycles after tx_done, required >= 3", first_gap[1]); end
   endtask

   task automatic test_timeout();
      int w;
      do_reset();
      push_pkt(0, 8'h51, 8'h00, 8'h00, 1);
      push_pkt(1, 8'h71, 8'h00, 8'h00, 1);
      push_pkt(0, 8'hD1, 8'h00, 8'h00, 1);
      fork
         begin
            drive(0, 8'h51, 8'h00, 8'h00, 1, 1'b0);
            w = 0;
            while (abort_cnt < 1 && w < 500) begin @(negedge clk); #1; w++; end
            drive(0, 8'hD1, 8'h00, 8'h00, 1, 1'b1);
         end
         begin
            wait_trmt(0, 1);
            drive(1, 8'h71, 8'h00, 8'h00, 1, 1'b1);
         end
      join
      wait_idle("timeout");
      checks++; if (abort_cnt != 1)
         begin errors++; $display("FAIL timeout_abort_cnt: got %0d aborts, required 1", abort_cnt); end
      checks++; if (abort_gap != TMO)
         begin errors++; $display("FAIL timeout_abort_time: got abort %0d cycles after tx_done, required %0d", abort_gap, TMO); end
   endtask

   task automatic test_reset_mid();
      int w;
      do_reset();
      done_en = 1'b0;
      push_pkt(0, 8'h66, 8'h00, 8'h00, 1);
      @(negedge clk);
      set_rq(0, 1'b1, 8'h66, 1'b0);
      w = 0;
      while (trmt_cnt[0] < 1 && w < 100) begin @(negedge clk); #1; w++; end
      checks++; if (trmt_cnt[0] < 1) begin errors++; $display("FAIL rmid_trmt: got no trmt, required 1"); end
      set_rq(0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant: got %b, required 00", grant); end
      checks++; if (uart_tx !== 8'h00) begin errors++; $display("FAIL rmid_uart_tx: got %02h, required 00", uart_tx); end
      checks++; if ({uart_trmt, rq0_ready, rq1_ready, abort} !== 4'b0000)
         begin errors++; $display("FAIL rmid_pulses: got trmt/rdy0/rdy1/abort=%b, required 0000", {uart_trmt, rq0_ready, rq1_ready, abort}); end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tx_done_man = 1'b1;
      @(negedge clk);
      tx_done_man = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checks++; if (grant !== 2'b00 || trmt_cnt[0] != 1 || uart_trmt !== 1'b0)
         begin errors++; $display("FAIL rmid_late_done: got grant=%b trmts=%0d trmt=%b, required 00/1/0", grant, trmt_cnt[0], uart_trmt); end
      done_en = 1'b1;
   endtask

   task automatic test_one_byte();
      do_reset();
      push_pkt(1, 8'h7F, 8'h00, 8'h00, 1);
      drive(1, 8'h7F, 8'h00, 8'h00, 1, 1'b1);
      wait_idle("one_byte");
      checks++; if (trmt_cnt[1] != HDR_N + 1)
         begin errors++; $display("FAIL one_byte_count: got %0d trmts, required %0d", trmt_cnt[1], HDR_N + 1); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wait_owner();
      test_timeout();
      test_reset_mid();
      test_one_byte();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
